interrupt_sequencer: RTL

- Consumes the registered EIX/DIX/RETIX/HALTX strobes from the general-group decoder.
- Owns the architectural interrupt-enable flag and latches external interrupt requests.
- Selects the highest-priority pending request and hands a vector to the control sequencer via a take/ack handshake.
- Parks the CPU in a halted state until a qualifying interrupt arrives.

---
 rtl/interrupt_sequencer_pkg.sv | 27 ++
 rtl/interrupt_sequencer_irq_priority_encoder.sv | 24 ++
 rtl/interrupt_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and constants for the interrupt sequencer and its helpers.
// State encodings, vector defaults and the vector address helper.
package interrupt_sequencer_pkg;

    typedef enum logic [1:0] {
        INT_ST_RUN       = 2'd0,
        INT_ST_HALTED    = 2'd1,
        INT_ST_VECTORING = 2'd2,
        INT_ST_SERVICING = 2'd3
    } int_state_e;

    localparam logic [15:0] INT_VECTOR_BASE_DEF   = 16'h0004;
    localparam int          INT_VECTOR_STRIDE_DEF = 4;
    localparam int          INT_IDX_W             = 3;

    // Address arithmetic is deliberately 16-bit so large indices wrap.
    function automatic logic [15:0] int_vector_addr(
        input logic [15:0]          base,
        input logic [15:0]          stride,
        input logic [INT_IDX_W-1:0] idx
    );
        logic [15:0] offset;
        offset = stride * {{(16-INT_IDX_W){1'b0}}, idx};
        return base + offset;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_irq_priority_encoder.sv
// Combinational fixed-priority encoder: lowest set index wins.
// Reports the winning index and whether any request is set.
module irq_priority_encoder #(
    parameter int NUM_IRQ = 4,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    // Scan high to low so the last assignment is the lowest set index.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: IE flag, IRQ edge latch, priority take/ack handshake, halt.
// Build option INT_WAKE_WHEN_DISABLED_EN: a pending request wakes HALTED to RUN when IE=0.
//
// state            | meaning
// -----------------+-----------------------------------------------------
// INT_ST_RUN       | normal execution, takes at instruction boundaries
// INT_ST_HALTED    | CPU parked, waiting for a qualifying request
// INT_ST_VECTORING | INT_TAKE high, vector held until INT_ACK
// INT_ST_SERVICING | handler running, no nesting until RETIX
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter int          NUM_IRQ       = 4,
    parameter logic [15:0] VECTOR_BASE   = INT_VECTOR_BASE_DEF,
    parameter int          VECTOR_STRIDE = INT_VECTOR_STRIDE_DEF
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               eix_i,
    input  logic               dix_i,
    input  logic               retix_i,
    input  logic               haltx_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               instr_boundary_i,
    input  logic               int_ack_i,
    output logic               ie_o,
    output logic [NUM_IRQ-1:0] pending_o,
    output logic               int_take_o,
    output logic [15:0]        int_vector_o,
    output logic               halted_o,
    output logic               in_service_o
);

    int_state_e             state_q, state_d;
    logic                   ie_q, ie_d;
    logic [NUM_IRQ-1:0]     pending_q, pending_d;
    logic [NUM_IRQ-1:0]     irq_q;
    logic [INT_IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]            vector_q, vector_d;

    logic [NUM_IRQ-1:0]     irq_edge;
    logic [NUM_IRQ-1:0]     ack_mask;
    logic [INT_IDX_W-1:0]   enc_idx;
    logic                   enc_valid;
    logic [15:0]            enc_vector;

    irq_priority_encoder #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (INT_IDX_W)
    ) u_prio (
        .req_i   (pending_q),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    assign irq_edge   = irq_i & ~irq_q;
    assign ack_mask   = NUM_IRQ'(1) << idx_q;
    assign enc_vector = int_vector_addr(VECTOR_BASE, 16'(VECTOR_STRIDE), enc_idx);

    always_comb begin
        state_d   = state_q;
        ie_d      = ie_q;
        idx_d     = idx_q;
        vector_d  = vector_q;
        pending_d = pending_q | irq_edge;

        unique case (state_q)
            INT_ST_RUN: begin
                if (dix_i)      ie_d = 1'b0;
                else if (eix_i) ie_d = 1'b1;
                if (haltx_i) begin
                    state_d = INT_ST_HALTED;
                end else if (instr_boundary_i && ie_q && enc_valid) begin
                    state_d  = INT_ST_VECTORING;
                    idx_d    = enc_idx;
                    vector_d = enc_vector;
                end
            end
            INT_ST_HALTED: begin
                if (dix_i)      ie_d = 1'b0;
                else if (eix_i) ie_d = 1'b1;
                if (ie_q && enc_valid) begin
                    state_d  = INT_ST_VECTORING;
                    idx_d    = enc_idx;
                    vector_d = enc_vector;
                end
`ifdef INT_WAKE_WHEN_DISABLED_EN
                else if (!ie_q && enc_valid) begin
                    state_d = INT_ST_RUN;
                end
`endif
            end
            INT_ST_VECTORING: begin
                ie_d = 1'b0;
                // A fresh edge on the acknowledged index survives the clear.
                if (int_ack_i) begin
                    pending_d = (pending_q & ~ack_mask) | irq_edge;
                    state_d   = INT_ST_SERVICING;
                end
            end
            INT_ST_SERVICING: begin
                if (retix_i) begin
                    ie_d    = 1'b1;
                    state_d = INT_ST_RUN;
                end else if (dix_i) begin
                    ie_d = 1'b0;
                end else if (eix_i) begin
                    ie_d = 1'b1;
                end
            end
            default: state_d = INT_ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= INT_ST_RUN;
            ie_q      <= 1'b0;
            pending_q <= '0;
            irq_q     <= '0;
            idx_q     <= '0;
            vector_q  <= '0;
        end else begin
            state_q   <= state_d;
            ie_q      <= ie_d;
            pending_q <= pending_d;
            irq_q     <= irq_i;
            idx_q     <= idx_d;
            vector_q  <= vector_d;
        end
    end

    assign ie_o         = ie_q;
    assign pending_o    = pending_q;
    assign int_take_o   = (state_q == INT_ST_VECTORING);
    assign int_vector_o = vector_q;
    assign halted_o     = (state_q == INT_ST_HALTED);
    assign in_service_o = (state_q == INT_ST_SERVICING);

endmodule
